ctrl_coef_phase_seq: RTL and testbench
======================================

# ctrl_coef_phase_seq

Polyphase coefficient sequencer for the sample-rate-converter controller. For each output sample it computes the coefficient start address of the current polyphase branch and drives the coefficient address counter's command inputs (`coef_clr`, `coef_load`, `coef_cnt`, `coef_ptr`) so that counter walks exactly one branch. It then advances the phase accumulator by the decimation step and reports how many input samples the data path must consume before the next output sample.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 12: coefficient RAM address width; must match the coefficient counter.
- `PHASE_WIDTH`, default 8: width of the phase, phase-count, step and advance values.
- `TAP_WIDTH`, default 8: width of the taps-per-phase value.

**Ports** (clock and reset first)
- `clk`, in, 1: single system clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request one output-sample sequence. Accepted only in IDLE.
- `phase_rst`, in, 1: synchronous phase restart. Accepted only in IDLE when `start`=0.
- `coef_base`, in, ADDR_WIDTH: address of phase 0, tap 0.
- `taps`, in, TAP_WIDTH: taps per polyphase branch.
- `num_phases`, in, PHASE_WIDTH: interpolation factor L. The value 0 is treated as 1.
- `phase_step`, in, PHASE_WIDTH: decimation step M. Any value is legal, including M ≥ L.
- `coef_clr`, out, 1: clear command to the coefficient counter.
- `coef_load`, out, 1: load command to the coefficient counter.
- `coef_cnt`, out, 1: count command to the coefficient counter.
- `coef_ptr`, out, ADDR_WIDTH: load value for the coefficient counter.
- `tap_valid`, out, 1: high in every cycle in which the counter output holds a valid tap address.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse; `in_adv` is valid in this cycle.
- `in_adv`, out, PHASE_WIDTH: number of input samples to consume. Held until the next `start`.
- `phase`, out, PHASE_WIDTH: current phase index.

## Operation

- **Reset:** all outputs and registers are 0, including `phase`, `in_adv`, `coef_ptr`, `busy` and `done`. The state is IDLE.
- **Reset mid-operation:** `rst` aborts immediately, returns the state to IDLE and zeroes everything. No `done` pulse is produced.
- **Configuration inputs** are sampled every cycle. They must be held stable while `busy`=1. Behaviour under violation is unspecified, but the FSM must still return to IDLE.
- **States:** IDLE, LOAD, RUN, ADV, WRAP, DONE.
- **IDLE:**
  - On `start`: register `coef_ptr` = (`coef_base` + `phase`·`taps`) truncated to ADDR_WIDTH (modulo 2^ADDR_WIDTH), clear `in_adv`, and go to LOAD.
  - Otherwise, on `phase_rst`: set `phase` to 0 and pulse `coef_clr` for one cycle (the cycle after the request); stay in IDLE.
- **LOAD:** `coef_load`=1 for exactly one cycle. Go to RUN if `taps`≠0, otherwise to ADV.
- **RUN:** lasts exactly `taps` cycles and `tap_valid`=1 in every one of them. `coef_cnt`=1 in the first `taps`−1 of those cycles; in the last cycle `coef_cnt`=0 and the FSM goes to ADV. The counter therefore presents `coef_ptr` … `coef_ptr`+`taps`−1, one address per cycle.
- **ADV:** `phase` ← `phase` + `phase_step`, computed at PHASE_WIDTH+1 bits internally with no overflow loss. Go to WRAP.
- **WRAP:** if `phase` ≥ L, then `phase` ← `phase` − L and `in_adv` ← `in_adv`+1 (one subtraction per cycle) and stay in WRAP; otherwise go to DONE. `in_adv` saturates at all-ones.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Command exclusivity:** at most one of `coef_clr`, `coef_load`, `coef_cnt` is high in any cycle.
- **`start` outside IDLE** is ignored and is not queued.

## Timing

- All outputs are registered.
- `start` sampled high at edge 0 gives:
  - LOAD in cycle 1;
  - RUN in cycles 2 … T+1, where T=`taps`;
  - ADV in cycle T+2;
  - WRAP for w+1 cycles, where w = number of wraps;
  - `done` in cycle T+4+w.
- With T=0, ADV falls in cycle 2 and `done` in cycle 4+w.
- The next `start` is accepted in the cycle after `done`.
- `coef_ptr` is stable from cycle 1 until the next accepted `start`.

## Test plan

- **Reset values:** assert `rst` asynchronously mid-cycle → all outputs 0 with no clock edge; release → IDLE, `busy`=0.
- **Basic sequence:** `coef_base`=0x100, T=4, L=2, M=3, `phase`=0, pulse `start`:
  - `coef_ptr`=0x100, `coef_load` in cycle 1;
  - `coef_cnt` in cycles 2–4, `tap_valid` in cycles 2–5;
  - `done` in cycle 9 with `in_adv`=1 and `phase`=1.
- **Second sequence:** repeat the same `start` → `coef_ptr`=0x104, `phase`=0, `in_adv`=2.
- **Large step:** L=3, M=7, T=1 → two wraps, `done` in cycle 7, `in_adv`=2, `phase`=1.
- **Degenerate configs:** T=0 → no `coef_cnt`/`tap_valid`, `done` at cycle 4+w. L=0 → `phase` stays 0 and `in_adv`=M.
- **Control edge cases:**
  - `phase_rst` in IDLE → `coef_clr` single pulse and `phase`=0.
  - `start` while `busy` → ignored.
  - `rst` during RUN → no `done` and all outputs 0.

Source files
------------

// File: rtl/ctrl_coef_phase_seq.sv
// rtl/ctrl_coef_phase_seq.sv - polyphase coefficient sequencer driving the coefficient address counter
// One start walks a single polyphase branch, then advances the phase by the decimation step.
module ctrl_coef_phase_seq #(
  parameter int ADDR_WIDTH  = 12,
  parameter int PHASE_WIDTH = 8,
  parameter int TAP_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   phase_rst,
  input  logic [ADDR_WIDTH-1:0]  coef_base,
  input  logic [TAP_WIDTH-1:0]   taps,
  input  logic [PHASE_WIDTH-1:0] num_phases,
  input  logic [PHASE_WIDTH-1:0] phase_step,
  output logic                   coef_clr,
  output logic                   coef_load,
  output logic                   coef_cnt,
  output logic [ADDR_WIDTH-1:0]  coef_ptr,
  output logic                   tap_valid,
  output logic                   busy,
  output logic                   done,
  output logic [PHASE_WIDTH-1:0] in_adv,
  output logic [PHASE_WIDTH-1:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_ADV, S_WRAP, S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [PHASE_WIDTH:0]           phase_q, phase_d;
  logic [TAP_WIDTH-1:0]           tap_cnt_q, tap_cnt_d;
  logic [PHASE_WIDTH-1:0]         in_adv_d;
  logic [ADDR_WIDTH-1:0]          ptr_d;
  logic                           clr_d, load_d, cnt_d, tv_d, done_d;
  logic [PHASE_WIDTH+TAP_WIDTH-1:0] prod;
  logic [PHASE_WIDTH:0]           l_eff;

  assign prod  = phase_q[PHASE_WIDTH-1:0] * taps;
  // L=0 behaves as L=1 so the wrap loop always terminates
  assign l_eff = (num_phases == '0) ? (PHASE_WIDTH+1)'(1) : {1'b0, num_phases};
  assign phase = phase_q[PHASE_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      tap_cnt_q <= '0;
      in_adv    <= '0;
      coef_ptr  <= '0;
      coef_clr  <= 1'b0;
      coef_load <= 1'b0;
      coef_cnt  <= 1'b0;
      tap_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tap_cnt_q <= tap_cnt_d;
      in_adv    <= in_adv_d;
      coef_ptr  <= ptr_d;
      coef_clr  <= clr_d;
      coef_load <= load_d;
      coef_cnt  <= cnt_d;
      tap_valid <= tv_d;
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
    end
  end

  // Output registers are loaded with the values for the state being entered
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tap_cnt_d = tap_cnt_q;
    in_adv_d  = in_adv;
    ptr_d     = coef_ptr;
    clr_d     = 1'b0;
    load_d    = 1'b0;
    cnt_d     = 1'b0;
    tv_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d    = coef_base + ADDR_WIDTH'(prod);
          in_adv_d = '0;
          load_d   = 1'b1;
          state_d  = S_LOAD;
        end else if (phase_rst) begin
          phase_d = '0;
          clr_d   = 1'b1;
        end
      end
      S_LOAD: begin
        if (taps != '0) begin
          tap_cnt_d = taps - 1'b1;
          cnt_d     = (taps > TAP_WIDTH'(1));
          tv_d      = 1'b1;
          state_d   = S_RUN;
        end else begin
          state_d = S_ADV;
        end
      end
      S_RUN: begin
        // tap_cnt_q counts the RUN cycles still to come after this one
        if (tap_cnt_q == '0) begin
          state_d = S_ADV;
        end else begin
          tap_cnt_d = tap_cnt_q - 1'b1;
          cnt_d     = (tap_cnt_q > TAP_WIDTH'(1));
          tv_d      = 1'b1;
        end
      end
      S_ADV: begin
        phase_d = phase_q + {1'b0, phase_step};
        state_d = S_WRAP;
      end
      S_WRAP: begin
        if (phase_q >= l_eff) begin
          phase_d  = phase_q - l_eff;
          in_adv_d = (in_adv == '1) ? in_adv : in_adv + 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_coef_phase_seq.sv
// tb/tb_ctrl_coef_phase_seq.sv - directed vector bench for ctrl_coef_phase_seq
module tb_ctrl_coef_phase_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        phase_rst = 1'b0;
  logic [11:0] coef_base = '0;
  logic [7:0]  taps = '0;
  logic [7:0]  num_phases = '0;
  logic [7:0]  phase_step = '0;
  logic        coef_clr, coef_load, coef_cnt, tap_valid, busy, done;
  logic [11:0] coef_ptr;
  logic [7:0]  in_adv, phase;

  int tests = 0;
  int fails = 0;

  ctrl_coef_phase_seq #(.ADDR_WIDTH(12), .PHASE_WIDTH(8), .TAP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .phase_rst(phase_rst),
    .coef_base(coef_base), .taps(taps), .num_phases(num_phases), .phase_step(phase_step),
    .coef_clr(coef_clr), .coef_load(coef_load), .coef_cnt(coef_cnt), .coef_ptr(coef_ptr),
    .tap_valid(tap_valid), .busy(busy), .done(done), .in_adv(in_adv), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] base;
    logic [7:0]  t;
    logic [7:0]  l;
    logic [7:0]  m;
    logic [11:0] e_ptr;
    int          e_done;
    logic [7:0]  e_adv;
    logic [7:0]  e_phase;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {30'd0, coef_clr, coef_load, coef_cnt, coef_ptr, tap_valid, busy, done, in_adv, phase};
  endfunction

  // Runs one sequence; cycle c is the interval after the c-th rising edge past the start sample
  task automatic run_vec(input vec_t v, input int poke);
    coef_base  = v.base;
    taps       = v.t;
    num_phases = v.l;
    phase_step = v.m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= v.e_done; c++) begin
      @(negedge clk);
      check("load", coef_load, c == 1);
      check("cnt", coef_cnt, (c >= 2) && (c <= int'(v.t)));
      check("tap_valid", tap_valid, (c >= 2) && (c <= int'(v.t) + 1));
      check("clr", coef_clr, 0);
      check("done", done, c == v.e_done);
      check("busy", busy, 1);
      check("coef_ptr", coef_ptr, v.e_ptr);
      start = (c == poke);
    end
    start = 1'b0;
    check("in_adv", in_adv, v.e_adv);
    check("phase", phase, v.e_phase);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("in_adv_hold", in_adv, v.e_adv);
      check("ptr_hold", coef_ptr, v.e_ptr);
    end
  endtask

  initial begin
    vecs[0] = '{12'h100, 8'd4,  8'd2, 8'd3, 12'h100, 9,  8'd1, 8'd1};
    vecs[1] = '{12'h100, 8'd4,  8'd2, 8'd3, 12'h104, 10, 8'd2, 8'd0};
    vecs[2] = '{12'h100, 8'd1,  8'd3, 8'd7, 12'h100, 7,  8'd2, 8'd1};
    vecs[3] = '{12'h200, 8'd0,  8'd3, 8'd2, 12'h200, 5,  8'd1, 8'd0};
    vecs[4] = '{12'h010, 8'd2,  8'd0, 8'd5, 12'h010, 11, 8'd5, 8'd0};
    vecs[5] = '{12'hFF0, 8'd16, 8'd4, 8'd1, 12'hFF0, 20, 8'd0, 8'd1};
    vecs[6] = '{12'hFF0, 8'd16, 8'd4, 8'd1, 12'h000, 20, 8'd0, 8'd2};

    #12;
    check("reset_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_outs", all_outs(), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 0);

    // phase restart from phase 2
    @(negedge clk);
    phase_rst = 1'b1;
    @(posedge clk);
    #1 phase_rst = 1'b0;
    @(negedge clk);
    check("phase_rst_clr", coef_clr, 1);
    check("phase_rst_phase", phase, 0);
    check("phase_rst_busy", busy, 0);
    @(negedge clk);
    check("phase_rst_clr_pulse", coef_clr, 0);

    // start while busy must be ignored and not queued
    run_vec(vecs[0], 3);

    // asynchronous reset during RUN
    coef_base = 12'h100;
    taps = 8'd4;
    num_phases = 8'd2;
    phase_step = 8'd3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("run_before_rst", tap_valid, 1);
    #1 rst = 1'b1;
    #1 check("async_rst_outs", all_outs(), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
      check("rst_held_outs", all_outs(), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_busy", busy, 0);
    check("after_rst_done", done, 0);
    run_vec(vecs[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
